// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;
    localparam logic        HIGH            = 1'b1;
    localparam logic        LOW             = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// First-word-fall-through FIFO with synchronous clear; head is valid whenever count_o > 0.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues in-order word reads for the PC stream, pairs responses with
// their PC and buffers them for decode; wrong-path responses are discarded after a clear.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int          OUTSTANDING_MAX    = 2,
    parameter int          FETCH_BUFFER_DEPTH = 2,
    parameter logic [31:0] NOP_INSTRUCTION    = instruction_fetch_unit_pkg::NOP_INSTRUCTION
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] PC,
    input  logic        PC_VALID,
    input  logic        CLEAR_INSTRUCTION_FETCH_STAGE,
    input  logic        STALL_INSTRUCTION_FETCH_STAGE,
    output logic        STALL_PROGRAME_COUNTER_STAGE,
    output logic        IMEM_REQ_VALID,
    input  logic        IMEM_REQ_READY,
    output logic [31:0] IMEM_REQ_ADDR,
    input  logic        IMEM_RESP_VALID,
    input  logic [31:0] IMEM_RESP_DATA,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_FETCHED,
    output logic        INSTRUCTION_VALID
);

    localparam int            OW      = $clog2(OUTSTANDING_MAX + 1);
    localparam int            BW      = $clog2(FETCH_BUFFER_DEPTH + 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(OUTSTANDING_MAX);

    fetch_state_e  state_q;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] discard_q, discard_d;
    logic          live_q;

    logic          clear;
    logic          can_issue;
    logic          req_fire;
    logic          resp_accept;
    logic          buf_pop;
    logic [31:0]   credit_sum;
    logic [31:0]   pend_head;
    logic [OW-1:0] pend_count;
    logic [63:0]   buf_head;
    logic [BW-1:0] buf_count;

    assign clear      = CLEAR_INSTRUCTION_FETCH_STAGE;
    // Credit uses registered counts only, so a same-cycle pop never frees a slot.
    assign credit_sum = 32'(outstanding_q) + 32'(buf_count);
    assign can_issue  = live_q && (state_q != FLUSH) && !clear
                     && (outstanding_q < OUT_MAX)
                     && (credit_sum < 32'(FETCH_BUFFER_DEPTH));

    assign IMEM_REQ_VALID               = PC_VALID && can_issue;
    assign IMEM_REQ_ADDR                = {PC[31:2], 2'b00};
    assign req_fire                     = IMEM_REQ_VALID && IMEM_REQ_READY;
    assign STALL_PROGRAME_COUNTER_STAGE = live_q && PC_VALID && !clear && !req_fire;

    // Responses are kept only when nothing is owed to the discard count and no clear is in progress.
    assign resp_accept = IMEM_RESP_VALID && (discard_q == '0) && !clear;

    assign INSTRUCTION_VALID = (buf_count != '0) && (state_q != FLUSH);
    assign buf_pop           = INSTRUCTION_VALID && !STALL_INSTRUCTION_FETCH_STAGE;
    assign INSTRUCTION       = INSTRUCTION_VALID ? buf_head[31:0]  : NOP_INSTRUCTION;
    assign PC_FETCHED        = INSTRUCTION_VALID ? buf_head[63:32] : 32'h0;

    always_comb begin
        outstanding_d = outstanding_q + OW'(req_fire) - OW'(IMEM_RESP_VALID);
        discard_d     = discard_q;
        if (clear) begin
            discard_d = outstanding_q - OW'(IMEM_RESP_VALID);
        end else if (IMEM_RESP_VALID && (discard_q != '0)) begin
            discard_d = discard_q - OW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            outstanding_q <= '0;
            discard_q     <= '0;
            live_q        <= LOW;
        end else begin
            live_q        <= HIGH;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            unique case (state_q)
                IDLE:    if (live_q && PC_VALID && !clear) state_q <= FETCH;
                FETCH:   if (clear && ((outstanding_q != '0) || IMEM_RESP_VALID)) state_q <= FLUSH;
                FLUSH:   if (discard_d == '0) state_q <= FETCH;
                default: state_q <= IDLE;
            endcase
        end
    end

    fetch_fifo #(.WIDTH(32), .DEPTH(OUTSTANDING_MAX)) u_pending_pc (
        .clk         (CLK),
        .rst_n       (RST_N),
        .clear_i     (clear),
        .push_i      (req_fire),
        .push_data_i (PC),
        .pop_i       (resp_accept),
        .head_o      (pend_head),
        .count_o     (pend_count)
    );

    fetch_fifo #(.WIDTH(64), .DEPTH(FETCH_BUFFER_DEPTH)) u_fetch_buffer (
        .clk         (CLK),
        .rst_n       (RST_N),
        .clear_i     (clear),
        .push_i      (resp_accept),
        .push_data_i ({pend_head, IMEM_RESP_DATA}),
        .pop_i       (buf_pop),
        .head_o      (buf_head),
        .count_o     (buf_count)
    );

    // Every live request either has a pending PC or is owed to the discard count.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            assert (outstanding_q <= OUT_MAX);
            assert (buf_count <= BW'(FETCH_BUFFER_DEPTH));
            assert (pend_count == outstanding_q - discard_q);
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: memory model plus in-order scoreboard of {pc, data}.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] PC;
    logic        PC_VALID;
    logic        CLEAR_INSTRUCTION_FETCH_STAGE;
    logic        STALL_INSTRUCTION_FETCH_STAGE;
    logic        STALL_PROGRAME_COUNTER_STAGE;
    logic        IMEM_REQ_VALID;
    logic        IMEM_REQ_READY;
    logic [31:0] IMEM_REQ_ADDR;
    logic        IMEM_RESP_VALID;
    logic [31:0] IMEM_RESP_DATA;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC_FETCHED;
    logic        INSTRUCTION_VALID;

    instruction_fetch_unit dut (
        .CLK                           (CLK),
        .RST_N                         (RST_N),
        .PC                            (PC),
        .PC_VALID                      (PC_VALID),
        .CLEAR_INSTRUCTION_FETCH_STAGE (CLEAR_INSTRUCTION_FETCH_STAGE),
        .STALL_INSTRUCTION_FETCH_STAGE (STALL_INSTRUCTION_FETCH_STAGE),
        .STALL_PROGRAME_COUNTER_STAGE  (STALL_PROGRAME_COUNTER_STAGE),
        .IMEM_REQ_VALID                (IMEM_REQ_VALID),
        .IMEM_REQ_READY                (IMEM_REQ_READY),
        .IMEM_REQ_ADDR                 (IMEM_REQ_ADDR),
        .IMEM_RESP_VALID               (IMEM_RESP_VALID),
        .IMEM_RESP_DATA                (IMEM_RESP_DATA),
        .INSTRUCTION                   (INSTRUCTION),
        .PC_FETCHED                    (PC_FETCHED),
        .INSTRUCTION_VALID             (INSTRUCTION_VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct { int due; logic [31:0] addr; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

    mreq_t mq[$];
    exp_t  sb[$];
    int    pop_cyc[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    mem_lat = 1;
    int    pops = 0;
    int    accs = 0;
    logic  last_acc, last_stall, last_req, last_ivalid;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (~a) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One clock: sample at negedge, then advance and drive the memory response.
    task automatic tick();
        exp_t  e;
        mreq_t m;
        @(negedge CLK);
        last_req    = IMEM_REQ_VALID;
        last_stall  = STALL_PROGRAME_COUNTER_STAGE;
        last_ivalid = INSTRUCTION_VALID;
        last_acc    = IMEM_REQ_VALID && IMEM_REQ_READY;
        if (last_acc) begin
            accs++;
            chk("req_addr", IMEM_REQ_ADDR, {PC[31:2], 2'b00});
            mq.push_back('{due: cyc + mem_lat, addr: {PC[31:2], 2'b00}});
            sb.push_back('{pc: PC, data: mem_data({PC[31:2], 2'b00})});
        end
        if (CLEAR_INSTRUCTION_FETCH_STAGE) begin
            sb.delete();
        end else if (INSTRUCTION_VALID && !STALL_INSTRUCTION_FETCH_STAGE) begin
            pops++;
            pop_cyc.push_back(cyc);
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $display("FAIL spurious_output observed pc=0x%08h expected no output", PC_FETCHED);
                $error("check spurious_output");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                $display("cycle %0d out pc=0x%08h instr=0x%08h", cyc, PC_FETCHED, INSTRUCTION);
                chk("pc_fetched", PC_FETCHED, e.pc);
                chk("instruction", INSTRUCTION, e.data);
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            IMEM_RESP_VALID = 1'b1;
            IMEM_RESP_DATA  = mem_data(m.addr);
        end else begin
            IMEM_RESP_VALID = 1'b0;
            IMEM_RESP_DATA  = 32'hDEAD_BEEF;
        end
    endtask

    // Present a PC and hold it until accepted (bounded).
    task automatic issue(input logic [31:0] pc, output int n);
        PC       = pc;
        PC_VALID = 1'b1;
        n        = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout pc=0x%08h observed no acceptance expected acceptance", pc);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, t0, a0, p0, st;
        RST_N = 1'b0;
        PC = 32'h0;
        PC_VALID = 1'b1;
        CLEAR_INSTRUCTION_FETCH_STAGE = 1'b0;
        STALL_INSTRUCTION_FETCH_STAGE = 1'b0;
        IMEM_REQ_READY = 1'b1;
        IMEM_RESP_VALID = 1'b0;
        IMEM_RESP_DATA = 32'h0;

        // Reset with PC_VALID asserted
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_valid", 32'(IMEM_REQ_VALID), 32'd0);
        chk("rst_instruction", INSTRUCTION, 32'h00000013);
        chk("rst_instr_valid", 32'(INSTRUCTION_VALID), 32'd0);
        chk("rst_pc_stall", 32'(STALL_PROGRAME_COUNTER_STAGE), 32'd0);
        chk("rst_pc_fetched", PC_FETCHED, 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("release_req_valid", 32'(IMEM_REQ_VALID), 32'd0);
        PC_VALID = 1'b0;
        @(posedge CLK);
        #1;

        // Streaming, 1-cycle memory
        p0 = pops;
        pop_cyc.delete();
        issue(32'h0, n);
        t0 = cyc - 1;
        issue(32'h4, n);
        issue(32'h8, n);
        chk("stream_credit_wait", n, 2);
        PC_VALID = 1'b0;
        repeat (4) tick();
        chk("stream_first_cycle", pop_cyc[0], t0 + 2);
        chk("stream_second_cycle", pop_cyc[1], t0 + 3);
        chk("stream_count", pops - p0, 3);
        chk("stream_drained", sb.size(), 0);

        // Memory back-pressure
        IMEM_REQ_READY = 1'b0;
        PC = 32'h10;
        PC_VALID = 1'b1;
        a0 = accs;
        st = 0;
        repeat (3) begin
            tick();
            st += int'(last_stall);
        end
        chk("bp_stall_cycles", st, 3);
        chk("bp_no_accept", accs - a0, 0);
        IMEM_REQ_READY = 1'b1;
        tick();
        chk("bp_stall_release", 32'(last_stall), 32'd0);
        PC_VALID = 1'b0;
        repeat (3) tick();
        chk("bp_single_req", accs - a0, 1);
        chk("bp_drained", sb.size(), 0);

        // Decode stall for 5 cycles
        STALL_INSTRUCTION_FETCH_STAGE = 1'b1;
        PC = 32'h40;
        PC_VALID = 1'b1;
        a0 = accs;
        p0 = pops;
        st = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (last_acc) PC = PC + 32'd4;
            st += int'(last_stall);
        end
        chk("dstall_accepts", accs - a0, 2);
        chk("dstall_pc_stall", st, 3);
        chk("dstall_no_pops", pops - p0, 0);
        chk("dstall_req_low", 32'(last_req), 32'd0);
        chk("dstall_valid_held", 32'(last_ivalid), 32'd1);
        STALL_INSTRUCTION_FETCH_STAGE = 1'b0;
        PC_VALID = 1'b0;
        repeat (3) tick();
        chk("dstall_drain_count", pops - p0, 2);
        chk("dstall_drained", sb.size(), 0);

        // Flush with two requests in flight on a 3-cycle memory
        mem_lat = 3;
        issue(32'h20, n);
        issue(32'h24, n);
        CLEAR_INSTRUCTION_FETCH_STAGE = 1'b1;
        PC = 32'h100;
        PC_VALID = 1'b1;
        tick();
        chk("flush_pc_stall", 32'(last_stall), 32'd0);
        chk("flush_req", 32'(last_req), 32'd0);
        CLEAR_INSTRUCTION_FETCH_STAGE = 1'b0;
        mem_lat = 1;
        p0 = pops;
        issue(32'h100, n);
        chk("flush_wait", n, 3);
        PC_VALID = 1'b0;
        repeat (3) tick();
        chk("flush_out_count", pops - p0, 1);
        chk("flush_drained", sb.size(), 0);

        // Clear coinciding with a response and a non-empty buffer
        STALL_INSTRUCTION_FETCH_STAGE = 1'b1;
        issue(32'h200, n);
        issue(32'h204, n);
        CLEAR_INSTRUCTION_FETCH_STAGE = 1'b1;
        PC = 32'h302;
        PC_VALID = 1'b1;
        chk("clr_resp_present", 32'(IMEM_RESP_VALID), 32'd1);
        tick();
        chk("clr_buf_nonempty", 32'(last_ivalid), 32'd1);
        CLEAR_INSTRUCTION_FETCH_STAGE = 1'b0;
        STALL_INSTRUCTION_FETCH_STAGE = 1'b0;
        p0 = pops;
        tick();
        chk("clr_ivalid_next", 32'(last_ivalid), 32'd0);
        issue(32'h302, n);
        chk("clr_refetch_wait", n, 1);
        PC_VALID = 1'b0;
        repeat (3) tick();
        chk("clr_out_count", pops - p0, 1);
        chk("clr_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
